key_debounce_fsm: RTL
=====================

KEY_DEBOUNCE_FSM -- requirements
Module: key_debounce_fsm

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500_000: consecutive stable cycles required to accept a level change (20 ms at 25 MHz).
REQ-002 Parameter LONG_CYC, default 25_000_000: cycles a debounced press must last before it is a long press (1 s at 25 MHz).
REQ-003 Parameter CNT_W, default 25: counter width; SHALL satisfy 2^CNT_W > max(DEBOUNCE_CYC, LONG_CYC).
REQ-004 ext_clk_25m  input  1  single system clock, 25 MHz; all state on its rising edge.
REQ-005 ext_rst_n  input  1  asynchronous active-low reset.
REQ-006 SW  input  1  raw mechanical switch, asynchronous, active-low (0 = pressed), bouncy.
REQ-007 key_level  output  1  debounced state, 1 = pressed.
REQ-008 key_down  output  1  one-cycle pulse on accepted press.
REQ-009 key_up  output  1  one-cycle pulse on accepted release.
REQ-010 key_long  output  1  one-cycle pulse when a press reaches LONG_CYC.
REQ-011 key_hold  output  1  level, high from key_long until accepted release.

Function
REQ-012 SW SHALL pass through a 2-flop synchronizer (sw_s); no other logic samples SW directly.
REQ-013 FSM states SHALL be IDLE, PRESS_FILT, PRESSED, LONG_HELD, REL_FILT; one shared counter cnt[CNT_W-1:0].
REQ-014 IDLE: sw_s=0 -> PRESS_FILT, cnt=1; else stay, cnt=0.
REQ-015 PRESS_FILT: sw_s=1 -> IDLE, cnt=0, no pulse; sw_s=0 and cnt=DEBOUNCE_CYC-1 -> PRESSED, cnt=0, key_down=1 for that cycle; otherwise cnt+1.
REQ-016 PRESSED: sw_s=0 and cnt=LONG_CYC-1 -> LONG_HELD, key_long=1 one cycle; sw_s=0 otherwise cnt+1; sw_s=1 -> REL_FILT, cnt=1.
REQ-017 LONG_HELD: cnt held at 0; sw_s=1 -> REL_FILT, cnt=1.
REQ-018 REL_FILT: sw_s=1 and cnt=DEBOUNCE_CYC-1 -> IDLE, cnt=0, key_up=1 one cycle; sw_s=0 (bounce) -> back to LONG_HELD if long_flag=1, else PRESSED with cnt=0 (long-press timing restarts); otherwise cnt+1.
REQ-019 long_flag SHALL set on entry to LONG_HELD and clear on entry to IDLE.
REQ-020 key_level SHALL be 1 in PRESSED, LONG_HELD, REL_FILT; 0 in IDLE, PRESS_FILT.
REQ-021 key_hold SHALL equal long_flag.
REQ-022 All outputs SHALL be registered; key_down, key_long, key_up never high simultaneously and never high two consecutive cycles.
REQ-023 Latency: with SW held low from first sampling edge E, key_down and key_level rise at edge E+2+DEBOUNCE_CYC; release latency identical for key_up.
REQ-024 key_long SHALL rise exactly LONG_CYC edges after key_down when no bounce occurs.
REQ-025 A release accepted before LONG_CYC SHALL produce key_up with no key_long.
REQ-026 cnt SHALL never wrap; counting stops at the transition thresholds above.
REQ-027 Undefined state encodings SHALL return to IDLE on the next edge with all pulses low.

Reset
REQ-028 ext_rst_n=0 SHALL immediately force state=IDLE, cnt=0, long_flag=0, both synchronizer flops=1, all outputs 0.
REQ-029 Reset asserted mid-press SHALL emit no key_up; after release of reset with SW still low, a fresh key_down SHALL follow per REQ-023.
REQ-030 Logic SHALL function from the first edge after ext_rst_n deasserts.

Verification (DEBOUNCE_CYC=8, LONG_CYC=40)
REQ-031 Clean press: SW 1->0 held 20 cycles -> key_down single pulse at E+10, key_level=1 thereafter, no key_long.
REQ-032 Bounce: SW toggles every 3 cycles for 30 cycles then low -> no pulse during toggling; exactly one key_down 10 edges after the last toggle.
REQ-033 Long press: SW low 80 cycles then high -> key_down at E+10, key_long at E+50, key_hold=1 E+50 until key_up, key_up 10 edges after release.
REQ-034 Release bounce in LONG_HELD: SW high 4 cycles, low 5, high steady -> no key_up for the 4-cycle glitch, key_hold stays 1, single key_up after steady high.
REQ-035 Reset mid-press: ext_rst_n low 3 cycles during PRESSED with SW low -> outputs 0 immediately, no key_up, new key_down 10 edges after reset release.
REQ-036 Short pulse: SW low exactly 7 cycles -> no output activity at all.

Source files
------------

// File: rtl/key_debounce_fsm_if.sv
// -----------------------------------------------------------------------------
// key_debounce_fsm_if
//
// Purpose: groups the raw switch input and the debounced key event outputs of
//          key_debounce_fsm into one bundle.
//
// Signals:
//   SW         raw mechanical switch, asynchronous, active-low (0 = pressed)
//   key_level  debounced state, 1 = pressed
//   key_down   one-cycle pulse on accepted press
//   key_up     one-cycle pulse on accepted release
//   key_long   one-cycle pulse when a press reaches the long-press time
//   key_hold   level, high from key_long until the accepted release
//
// Modports:
//   master  the switch side / event consumer: drives SW, observes key events
//   slave   the debouncer itself: samples SW, drives key events
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface key_debounce_fsm_if;

    logic SW;
    logic key_level;
    logic key_down;
    logic key_up;
    logic key_long;
    logic key_hold;

    modport master (
        output SW,
        input  key_level,
        input  key_down,
        input  key_up,
        input  key_long,
        input  key_hold
    );

    modport slave (
        input  SW,
        output key_level,
        output key_down,
        output key_up,
        output key_long,
        output key_hold
    );

endinterface : key_debounce_fsm_if

// File: rtl/key_debounce_fsm.sv
// -----------------------------------------------------------------------------
// key_debounce_fsm
//
// Purpose: debounces one bouncy, active-low mechanical push button and turns
//          it into clean key events: a debounced level, press/release pulses,
//          a long-press pulse and a long-hold level.
//
// Parameters:
//   DEBOUNCE_CYC  consecutive stable cycles needed to accept a level change
//   LONG_CYC      cycles a debounced press must last to count as a long press
//   CNT_W         width of the shared counter; 2^CNT_W must exceed both
//                 DEBOUNCE_CYC and LONG_CYC
//
// Ports:
//   ext_clk_25m   system clock, all state on its rising edge
//   ext_rst_n     asynchronous active-low reset
//   key_if        key_debounce_fsm_if.slave: SW in, key_level / key_down /
//                 key_up / key_long / key_hold out
//
// Timing: SW crosses a 2-flop synchronizer (sw_s). The FSM and its event
// flags form stage p0; every output is re-registered in stage p1, so all
// outputs appear one edge after the FSM decision. With SW held low from
// sampling edge E, key_down and key_level rise at edge E+2+DEBOUNCE_CYC.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module key_debounce_fsm #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int LONG_CYC     = 25_000_000,
    parameter int CNT_W        = 25
) (
    input  logic               ext_clk_25m,
    input  logic               ext_rst_n,
    key_debounce_fsm_if.slave  key_if
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_FILT = 3'd1,
        PRESSED    = 3'd2,
        LONG_HELD  = 3'd3,
        REL_FILT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Saturating increment: the counter must never wrap back to zero, even
    // if a threshold were somehow missed.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // Synchronizer flops (reset to the released level, 1)
    logic             sw_meta;
    logic             sw_s;

    // Stage p0: FSM state, shared counter, long-press flag, event flags
    state_t           state_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             long_flag_p0;
    logic             down_evt_p0;
    logic             up_evt_p0;
    logic             long_evt_p0;

    // Stage p1: registered outputs
    logic             key_level_p1;
    logic             key_down_p1;
    logic             key_up_p1;
    logic             key_long_p1;
    logic             key_hold_p1;

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            sw_meta      <= 1'b1;
            sw_s         <= 1'b1;
            state_p0     <= IDLE;
            cnt_p0       <= '0;
            long_flag_p0 <= 1'b0;
            down_evt_p0  <= 1'b0;
            up_evt_p0    <= 1'b0;
            long_evt_p0  <= 1'b0;
            key_level_p1 <= 1'b0;
            key_down_p1  <= 1'b0;
            key_up_p1    <= 1'b0;
            key_long_p1  <= 1'b0;
            key_hold_p1  <= 1'b0;
        end else begin
            sw_meta <= key_if.SW;
            sw_s    <= sw_meta;

            // ---- stage p0 -> p1 boundary: outputs follow the FSM by one edge
            key_level_p1 <= (state_p0 == PRESSED) || (state_p0 == LONG_HELD) ||
                            (state_p0 == REL_FILT);
            key_hold_p1  <= long_flag_p0;
            key_down_p1  <= down_evt_p0;
            key_up_p1    <= up_evt_p0;
            key_long_p1  <= long_evt_p0;

            // ---- stage p0: FSM; event flags default low so each lasts one cycle
            down_evt_p0 <= 1'b0;
            up_evt_p0   <= 1'b0;
            long_evt_p0 <= 1'b0;

            case (state_p0)
                IDLE: begin
                    if (!sw_s) begin
                        state_p0 <= PRESS_FILT;
                        cnt_p0   <= CNT_ONE;
                    end else begin
                        cnt_p0   <= '0;
                    end
                end

                PRESS_FILT: begin
                    if (sw_s) begin
                        // Bounce before the press was accepted: drop it silently.
                        state_p0     <= IDLE;
                        cnt_p0       <= '0;
                        long_flag_p0 <= 1'b0;
                    end else if (cnt_p0 >= DEB_LAST) begin
                        state_p0    <= PRESSED;
                        cnt_p0      <= '0;
                        down_evt_p0 <= 1'b1;
                    end else begin
                        cnt_p0 <= cnt_inc(cnt_p0);
                    end
                end

                PRESSED: begin
                    if (sw_s) begin
                        state_p0 <= REL_FILT;
                        cnt_p0   <= CNT_ONE;
                    end else if (cnt_p0 >= LONG_LAST) begin
                        state_p0     <= LONG_HELD;
                        cnt_p0       <= '0;
                        long_flag_p0 <= 1'b1;
                        long_evt_p0  <= 1'b1;
                    end else begin
                        cnt_p0 <= cnt_inc(cnt_p0);
                    end
                end

                LONG_HELD: begin
                    if (sw_s) begin
                        state_p0 <= REL_FILT;
                        cnt_p0   <= CNT_ONE;
                    end else begin
                        cnt_p0 <= '0;
                    end
                end

                REL_FILT: begin
                    if (!sw_s) begin
                        // Release bounce: return to the held state. A short
                        // press restarts its long-press timing from zero.
                        state_p0 <= long_flag_p0 ? LONG_HELD : PRESSED;
                        cnt_p0   <= '0;
                    end else if (cnt_p0 >= DEB_LAST) begin
                        state_p0     <= IDLE;
                        cnt_p0       <= '0;
                        long_flag_p0 <= 1'b0;
                        up_evt_p0    <= 1'b1;
                    end else begin
                        cnt_p0 <= cnt_inc(cnt_p0);
                    end
                end

                default: begin
                    // Illegal encoding: recover to IDLE with every pulse low.
                    state_p0     <= IDLE;
                    cnt_p0       <= '0;
                    long_flag_p0 <= 1'b0;
                    key_down_p1  <= 1'b0;
                    key_up_p1    <= 1'b0;
                    key_long_p1  <= 1'b0;
                end
            endcase
        end
    end

    assign key_if.key_level = key_level_p1;
    assign key_if.key_down  = key_down_p1;
    assign key_if.key_up    = key_up_p1;
    assign key_if.key_long  = key_long_p1;
    assign key_if.key_hold  = key_hold_p1;

endmodule : key_debounce_fsm
